// File: rtl/mul_pipe_unit.sv
// mul_pipe_unit: pipelined integer multiplier (MUL/MULH/MULHU) with valid/ready, flush and tag pass-through.
// Optional feature: define MUL_PERF_CNT_EN to add the perf_mul_cnt completed-result counter.
module mul_pipe_unit #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  src1,
  input  logic [WIDTH-1:0]  src2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [TAG_W-1:0]  out_tag
`ifdef MUL_PERF_CNT_EN
  ,
  output logic [31:0]       perf_mul_cnt
`endif
);

  logic              stall;
  logic              accept;
  logic [STAGES-1:0] vld;
  logic [1:0]        ops  [STAGES];
  logic [TAG_W-1:0]  tags [STAGES];
  logic [WIDTH:0]    ext1;
  logic [WIDTH:0]    ext2;
  logic [2*WIDTH-1:0] last_prod;
  logic              hi;

  // Low 2*WIDTH bits of the product of two (WIDTH+1)-bit two's-complement operands;
  // sign-extending to 2*WIDTH first makes an unsigned multiply give the right low bits.
  function automatic logic [2*WIDTH-1:0] mul_lo(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
    logic [2*WIDTH-1:0] xa;
    logic [2*WIDTH-1:0] xb;
    xa = {{(WIDTH-1){a[WIDTH]}}, a};
    xb = {{(WIDTH-1){b[WIDTH]}}, b};
    return xa * xb;
  endfunction

  assign out_valid = vld[STAGES-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready & ~flush;
  assign out_tag   = tags[STAGES-1];

  // Operand extension: only MULH treats operands as signed.
  always_comb begin
    ext1 = {(op == 2'b01) & src1[WIDTH-1], src1};
    ext2 = {(op == 2'b01) & src2[WIDTH-1], src2};
  end

  // Half selection on the last stage; reserved op 11 behaves as MUL.
  always_comb begin
    hi         = (ops[STAGES-1] == 2'b01) | (ops[STAGES-1] == 2'b10);
    out_result = hi ? last_prod[2*WIDTH-1:WIDTH] : last_prod[WIDTH-1:0];
  end

  // Control pipeline: valid bits, op and tag advance together unless stalled; flush kills everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) begin
        ops[i]  <= '0;
        tags[i] <= '0;
      end
    end else begin
      if (flush) begin
        vld <= '0;
      end else if (!stall) begin
        vld[0] <= accept;
        for (int i = 1; i < STAGES; i++) vld[i] <= vld[i-1];
      end
      if (!stall) begin
        ops[0]  <= op;
        tags[0] <= in_tag;
        for (int i = 1; i < STAGES; i++) begin
          ops[i]  <= ops[i-1];
          tags[i] <= tags[i-1];
        end
      end
    end
  end

  if (STAGES == 1) begin : g_one
    logic [2*WIDTH-1:0] p;
    // Single stage registers the finished product directly.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) p <= '0;
      else if (!stall) p <= mul_lo(ext1, ext2);
    end
    assign last_prod = p;
  end else begin : g_multi
    logic [WIDTH:0]     a;
    logic [WIDTH:0]     b;
    logic [2*WIDTH-1:0] p [STAGES-1];
    // Stage 1 holds extended operands; the product is formed into stage 2 and then carried.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        a <= '0;
        b <= '0;
        for (int i = 0; i < STAGES-1; i++) p[i] <= '0;
      end else if (!stall) begin
        a    <= ext1;
        b    <= ext2;
        p[0] <= mul_lo(a, b);
        for (int i = 1; i < STAGES-1; i++) p[i] <= p[i-1];
      end
    end
    assign last_prod = p[STAGES-2];
  end

`ifdef MUL_PERF_CNT_EN
  // Counts completed output handshakes; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_mul_cnt <= '0;
    else if (out_valid & out_ready) perf_mul_cnt <= perf_mul_cnt + 32'd1;
  end
`endif

endmodule
